// File: rtl/button_gesture_decoder.sv
// Debounced push-button gesture classifier.
// Reports short, long and double presses as one-cycle pulses.
module button_gesture_decoder #(
  parameter int LONG_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 15_000_000,
  parameter int CNT_W      = 26
) (
  input  logic clk_50MHz_i,
  input  logic rst_async_la_i,
  input  logic sw_clean_i,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic busy_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS1   = 2'd1;
  localparam logic [1:0] WAIT_GAP = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sw_clean_i) state_d = PRESS1;
      end
      PRESS1: begin
        // release outranks the long-press terminal count
        if (!sw_clean_i) begin
          state_d = WAIT_GAP;
        end else if (cnt_q == LONG_LAST) begin
          state_d = WAIT_REL;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_GAP: begin
        // re-press outranks the gap terminal count
        if (sw_clean_i) begin
          state_d  = WAIT_REL;
          double_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_REL: begin
        if (!sw_clean_i) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
    end
  end

  assign short_o  = short_q;
  assign long_o   = long_q;
  assign double_o = double_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Bench for button_gesture_decoder: vector table, corner sequences
// and a run-length reference model under random button traffic.
module tb_button_gesture_decoder;

  localparam int LT = 8;
  localparam int GT = 5;
  localparam int CW = 4;
  localparam int NR = 500;

  logic clk = 1'b0;
  logic rst_n;
  logic sw;
  logic s_o, l_o, d_o, b_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_gesture_decoder #(
    .LONG_TICKS(LT),
    .GAP_TICKS (GT),
    .CNT_W     (CW)
  ) dut (
    .clk_50MHz_i   (clk),
    .rst_async_la_i(rst_n),
    .sw_clean_i    (sw),
    .short_o       (s_o),
    .long_o        (l_o),
    .double_o      (d_o),
    .busy_o        (b_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // kind: 0 short, 1 long, 2 double; at: edge of pulse from press edge 0
  typedef struct {
    int h1;
    int g;
    int h2;
    int kind;
    int at;
  } vec_t;

  vec_t tbl[8];

  task automatic run_vec(input vec_t v, input int id);
    int ns, nl, nd, first, busy_at, multi;
    bit hi;
    ns = 0; nl = 0; nd = 0; first = -1; busy_at = -1; multi = 0;
    for (int k = 0; k < 40; k++) begin
      hi = (k < v.h1) ||
           (v.h2 > 0 && k >= v.h1 + v.g && k < v.h1 + v.g + v.h2);
      sw = hi;
      @(posedge clk); #1;
      if (k == 0) chk($sformatf("v%0d_busy_rise", id), int'(b_o), 1);
      if ((s_o | l_o | d_o) && first < 0) begin
        first   = k;
        busy_at = int'(b_o);
      end
      if (int'(s_o) + int'(l_o) + int'(d_o) > 1) multi++;
      ns += int'(s_o);
      nl += int'(l_o);
      nd += int'(d_o);
    end
    sw = 1'b0;
    chk($sformatf("v%0d_short_cnt", id), ns, int'(v.kind == 0));
    chk($sformatf("v%0d_long_cnt", id), nl, int'(v.kind == 1));
    chk($sformatf("v%0d_double_cnt", id), nd, int'(v.kind == 2));
    chk($sformatf("v%0d_pulse_edge", id), first, v.at);
    chk($sformatf("v%0d_busy_at_pulse", id), busy_at, int'(v.kind != 0));
    chk($sformatf("v%0d_onehot", id), multi, 0);
    chk($sformatf("v%0d_busy_end", id), int'(b_o), 0);
  endtask

  bit       sw_arr[NR];
  bit [3:0] exp_arr[NR];

  function automatic bit at_sw(int i);
    return (i >= 0 && i < NR) ? sw_arr[i] : 1'b0;
  endfunction

  function automatic void mark(int i, int b);
    if (i >= 0 && i < NR) exp_arr[i][b] = 1'b1;
  endfunction

  function automatic int run_len(int i, bit v);
    int n = 0;
    while ((i + n) < NR + 100 && at_sw(i + n) == v) n++;
    return n;
  endfunction

  // Gestures from run lengths: ones run h, zeros run g, etc.
  function automatic void build_model();
    int t, h, r, g, e;
    for (int i = 0; i < NR; i++) exp_arr[i] = 4'b0;
    t = 0;
    while (t < NR) begin
      if (!at_sw(t)) begin
        t++;
        continue;
      end
      h = run_len(t, 1'b1);
      if (h > LT) begin
        mark(t + LT, 2);
        e = t + h;
      end else begin
        r = t + h;
        g = run_len(r, 1'b0);
        if (g <= GT) begin
          mark(r + g, 1);
          e = r + g + run_len(r + g, 1'b1);
        end else begin
          mark(r + GT, 3);
          e = r + GT;
        end
      end
      for (int k = t; k < e; k++) mark(k, 0);
      t = e + 1;
    end
  endfunction

  initial begin
    int first, seq[$], idx, len;
    tbl[0] = '{3, 0, 0, 0, 8};
    tbl[1] = '{12, 0, 0, 1, 8};
    tbl[2] = '{3, 2, 3, 2, 5};
    tbl[3] = '{8, 0, 0, 0, 13};
    tbl[4] = '{3, 5, 2, 2, 8};
    tbl[5] = '{1, 0, 0, 0, 6};
    tbl[6] = '{9, 0, 0, 1, 8};
    tbl[7] = '{7, 0, 0, 0, 12};

    rst_n = 1'b0;
    sw    = 1'b0;
    #1;
    chk("reset_state", int'({s_o, l_o, d_o, b_o}), 0);
    #21 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // reset four cycles into the gap window
    sw = 1'b1;
    repeat (3) @(posedge clk);
    #1 sw = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("gap_busy_before_rst", int'(b_o), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", int'({s_o, l_o, d_o, b_o}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    first = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      first += int'(s_o | l_o | d_o | b_o);
    end
    chk("rst_no_short", first, 0);

    // button still held when reset releases
    rst_n = 1'b0;
    sw    = 1'b1;
    #3 rst_n = 1'b1;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 0) chk("rst_held_busy", int'(b_o), 1);
      if (l_o && first < 0) first = k;
    end
    chk("rst_held_long_edge", first, 8);
    sw = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // back-to-back: short, short, long
    for (int p = 0; p < 3; p++) begin
      len = (p == 2) ? 12 : 3;
      for (int k = 0; k < len + 10; k++) begin
        sw = (k < len);
        @(posedge clk); #1;
        if (s_o) seq.push_back(0);
        if (l_o) seq.push_back(1);
        if (d_o) seq.push_back(2);
      end
    end
    sw = 1'b0;
    chk("b2b_count", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("b2b_0", seq[0], 0);
      chk("b2b_1", seq[1], 0);
      chk("b2b_2", seq[2], 1);
    end

    // random traffic against the run-length model
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    idx = 0;
    while (idx < NR - 20) begin
      len = int'($urandom_range(1, 12));
      for (int k = 0; k < len && idx < NR - 20; k++) sw_arr[idx++] = 1'b1;
      len = int'($urandom_range(1, 8));
      for (int k = 0; k < len && idx < NR; k++) sw_arr[idx++] = 1'b0;
    end
    while (idx < NR) sw_arr[idx++] = 1'b0;
    build_model();
    for (int t = 0; t < NR; t++) begin
      sw = sw_arr[t];
      @(posedge clk); #1;
      chk($sformatf("rand_e%0d", t), int'({s_o, l_o, d_o, b_o}),
          int'(exp_arr[t]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
